data_bus_arbiter: RTL

//  Shares the single data-memory/peripheral bus (DataMem + Peripheral, common addr/wdata/rdata)

---
 rtl/data_bus_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/data_bus_arbiter.sv
// Two-master arbiter for the shared data-memory/peripheral bus: CPU port (M0) and DMA master (M1).
// Each access takes IDLE -> BUSY -> DONE; ties alternate round-robin, ack and read data are registered.
module data_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_rd,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  output logic              m0_stall,
  input  logic              m1_req,
  input  logic              m1_rd,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic              r_owner;
  logic              w_nextOwner;
  logic              r_lastGrant;
  logic              w_start;
  logic              r_m0Ack;
  logic              r_m1Ack;
  logic [DATA_W-1:0] r_m0Rdata;
  logic [DATA_W-1:0] r_m1Rdata;
  logic              w_busy;
  logic              w_ownRd;
  logic              w_ownWr;
  logic [ADDR_W-1:0] w_ownAddr;
  logic [DATA_W-1:0] w_ownWdata;

  // Only IDLE arbitrates, so a request still held during DONE is never served twice.
  always_comb begin
    w_nextState = r_state;
    w_nextOwner = r_owner;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (m0_req || m1_req) begin
          w_start     = 1'b1;
          w_nextState = BUSY;
          if (m0_req && m1_req) begin
            w_nextOwner = ~r_lastGrant;
          end else begin
            w_nextOwner = m1_req;
          end
        end
      end
      BUSY:    w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_owner     <= 1'b0;
      r_lastGrant <= 1'b1;
    end else begin
      r_state <= w_nextState;
      r_owner <= w_nextOwner;
      if (w_start) begin
        r_lastGrant <= w_nextOwner;
      end
    end
  end

  assign w_busy     = (r_state == BUSY);
  assign w_ownRd    = r_owner ? m1_rd    : m0_rd;
  assign w_ownWr    = r_owner ? m1_wr    : m0_wr;
  assign w_ownAddr  = r_owner ? m1_addr  : m0_addr;
  assign w_ownWdata = r_owner ? m1_wdata : m0_wdata;

  // Bus is quiet outside BUSY; an async reset therefore drops the strobes immediately.
  assign mem_rd    = w_busy & w_ownRd;
  assign mem_wr    = w_busy & w_ownWr;
  assign mem_addr  = w_busy ? w_ownAddr  : '0;
  assign mem_wdata = w_busy ? w_ownWdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m0Ack   <= 1'b0;
      r_m1Ack   <= 1'b0;
      r_m0Rdata <= '0;
      r_m1Rdata <= '0;
    end else begin
      r_m0Ack <= w_busy & ~r_owner;
      r_m1Ack <= w_busy &  r_owner;
      if (w_busy && !r_owner && m0_rd) begin
        r_m0Rdata <= mem_rdata;
      end
      if (w_busy && r_owner && m1_rd) begin
        r_m1Rdata <= mem_rdata;
      end
    end
  end

  assign m0_ack   = r_m0Ack;
  assign m1_ack   = r_m1Ack;
  assign m0_rdata = r_m0Rdata;
  assign m1_rdata = r_m1Rdata;
  assign m0_stall = m0_req & ~r_m0Ack;

endmodule
